// File: rtl/mp_add_seq.sv
// mp_add_seq
// Multi-precision add/subtract sequencer. Two requesters share one SLICE_W-bit
// carry-lookahead slice. A round-robin arbiter accepts one request, and the
// slice then runs once per cycle over NWORDS words, least-significant word
// first. The carry is chained through a register. The full-width result is
// returned on a valid/ready handshake.
//
// Optional feature: define MP_ADD_OVF_EN to add the rsp_ovf signed-overflow
// output. When the macro is undefined, the port and its logic are absent.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous active-high reset
//   req_valid  in   [1:0] per-requester request valid
//   req_ready  out  [1:0] per-requester accept strobe (one-hot or zero, combinational)
//   req_a0/b0  in   [W-1:0] requester 0 operands
//   req_a1/b1  in   [W-1:0] requester 1 operands
//   req_sub    in   [1:0] per-requester op select (1 = A-B, 0 = A+B)
//   rsp_valid  out  result valid
//   rsp_ready  in   consumer accepts result
//   rsp_data   out  [W-1:0] sum / difference
//   rsp_cout   out  carry out of the top slice (subtract: 1 = no borrow)
//   rsp_ovf    out  signed overflow (MP_ADD_OVF_EN only)
//   rsp_id     out  requester that owns the result
module mp_add_seq #(
  parameter int SLICE_W = 16,
  parameter int NWORDS  = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [1:0]                  req_valid,
  output logic [1:0]                  req_ready,
  input  logic [SLICE_W*NWORDS-1:0]   req_a0,
  input  logic [SLICE_W*NWORDS-1:0]   req_b0,
  input  logic [SLICE_W*NWORDS-1:0]   req_a1,
  input  logic [SLICE_W*NWORDS-1:0]   req_b1,
  input  logic [1:0]                  req_sub,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [SLICE_W*NWORDS-1:0]   rsp_data,
  output logic                        rsp_cout,
`ifdef MP_ADD_OVF_EN
  output logic                        rsp_ovf,
`endif
  output logic                        rsp_id
);

  localparam int W  = SLICE_W * NWORDS;
  localparam int KW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NWORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // One slice. Each 4-bit group resolves its carries in a single lookahead
  // level. Group generate/propagate then carry the result between groups.
  // The return value is {cout, sum}.
  function automatic logic [SLICE_W:0] cla_slice(input logic [SLICE_W-1:0] a,
                                                 input logic [SLICE_W-1:0] b,
                                                 input logic               cin);
    logic [SLICE_W-1:0] p, g, cv;
    logic               c, gg, gp;
    int                 o;
    p  = a ^ b;
    g  = a & b;
    c  = cin;
    cv = '0;
    for (int j = 0; j < SLICE_W / 4; j++) begin
      o         = 4 * j;
      cv[o]     = c;
      cv[o + 1] = g[o] | (p[o] & c);
      cv[o + 2] = g[o + 1] | (p[o + 1] & g[o]) | (p[o + 1] & p[o] & c);
      cv[o + 3] = g[o + 2] | (p[o + 2] & g[o + 1]) | (p[o + 2] & p[o + 1] & g[o])
                | (p[o + 2] & p[o + 1] & p[o] & c);
      gg = g[o + 3] | (p[o + 3] & g[o + 2]) | (p[o + 3] & p[o + 2] & g[o + 1])
         | (p[o + 3] & p[o + 2] & p[o + 1] & g[o]);
      gp = &p[o +: 4];
      c  = gg | (gp & c);
    end
    return {c, p ^ cv};
  endfunction

  state_t             r_state;
  logic               r_last_grant;
  logic [W-1:0]       r_a, r_b, r_res;
  logic               r_carry, r_cout, r_id, r_rsp_valid;
  logic [KW-1:0]      r_k;
`ifdef MP_ADD_OVF_EN
  logic               r_ovf;
`endif

  logic               w_g;
  logic               w_hs;
  logic [W-1:0]       w_op_a, w_op_b;
  logic               w_sub;
  logic [SLICE_W-1:0] w_a_word, w_b_word, w_sum;
  logic [SLICE_W:0]   w_slice;
  logic               w_cout;

  // When both requesters are valid, the grant goes to the one that was not
  // served last.
  always_comb begin
    w_g = 1'b0;
    case (req_valid)
      2'b10:   w_g = 1'b1;
      2'b11:   w_g = ~r_last_grant;
      default: w_g = 1'b0;
    endcase
  end

  assign req_ready = (r_state == IDLE && !reset && req_valid[w_g]) ?
                     (w_g ? 2'b10 : 2'b01) : 2'b00;
  assign w_hs      = |req_ready;
  assign w_op_a    = w_g ? req_a1 : req_a0;
  assign w_op_b    = w_g ? req_b1 : req_b0;
  assign w_sub     = req_sub[w_g];

  // The operands shift right one word per RUN cycle, so the slice always reads
  // the low word. The result fills in from the top and is aligned after
  // NWORDS shifts.
  assign w_a_word  = r_a[SLICE_W-1:0];
  assign w_b_word  = r_b[SLICE_W-1:0];
  assign w_slice   = cla_slice(w_a_word, w_b_word, r_carry);
  assign w_sum     = w_slice[SLICE_W-1:0];
  assign w_cout    = w_slice[SLICE_W];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
      r_rsp_valid  <= 1'b0;
      r_res        <= '0;
      r_cout       <= 1'b0;
      r_id         <= 1'b0;
      r_k          <= '0;
`ifdef MP_ADD_OVF_EN
      r_ovf        <= 1'b0;
`endif
    end else begin
      case (r_state)
        // IDLE: capture the granted operands. For subtract, invert B and
        // seed the carry with 1.
        IDLE: begin
          if (w_hs) begin
            r_a     <= w_op_a;
            r_b     <= w_sub ? ~w_op_b : w_op_b;
            r_carry <= w_sub;
            r_k     <= '0;
            r_id    <= w_g;
            r_state <= RUN;
          end
        end
        // RUN: process one word per cycle.
        RUN: begin
          r_a     <= r_a >> SLICE_W;
          r_b     <= r_b >> SLICE_W;
          r_carry <= w_cout;
          r_res   <= {w_sum, r_res[W-1:SLICE_W]};
          r_k     <= r_k + KW'(1);
          if (r_k == K_LAST) begin
            r_cout      <= w_cout;
`ifdef MP_ADD_OVF_EN
            // The carry into the top bit equals a ^ b ^ sum at that bit.
            r_ovf       <= w_a_word[SLICE_W-1] ^ w_b_word[SLICE_W-1]
                         ^ w_sum[SLICE_W-1] ^ w_cout;
`endif
            r_rsp_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        // DONE: hold the result until the consumer accepts it.
        DONE: begin
          if (rsp_ready) begin
            r_rsp_valid  <= 1'b0;
            r_last_grant <= r_id;
            r_state      <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_res;
  assign rsp_cout  = r_cout;
  assign rsp_id    = r_id;
`ifdef MP_ADD_OVF_EN
  assign rsp_ovf   = r_ovf;
`endif

endmodule

// File: doc/mp_add_seq.md
# mp_add_seq

Multi-precision add/subtract sequencer that shares one SLICE_W-bit carry-lookahead adder slice between two requesters. It arbitrates round-robin between the two request ports and captures the granted operands. It then runs the slice once per cycle over NWORDS words, least-significant first, chaining the carry through a register, and returns the full-width result with a valid/ready handshake. It sits between the control logic and the arithmetic datapath, so wide additions do not need a full-width lookahead tree.

## Interface
- SLICE_W, 16: slice width in bits; must be a multiple of 4 (built from 4-bit lookahead groups).
- NWORDS, 4: words per operand; operand width W = SLICE_W*NWORDS; NWORDS >= 2.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  2  per-requester request valid.
- req_ready  out  2  per-requester accept strobe (one-hot or zero).
- req_a0, req_b0  in  W  requester 0 operands.
- req_a1, req_b1  in  W  requester 1 operands.
- req_sub  in  2  per-requester op select: 1 = A−B, 0 = A+B.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accepts result.
- rsp_data  out  W  sum/difference.
- rsp_cout  out  1  final carry out (for subtract, 1 = no borrow).
- rsp_id  out  1  requester index that owns the result.
- rsp_ovf  out  1  signed overflow; present only with MP_ADD_OVF_EN.

## Operation
- Reset state: IDLE.
- Reset values: rsp_valid=0, rsp_data=0, rsp_cout=0, rsp_id=0, rsp_ovf=0, req_ready=0.
- Reset also sets last_grant=1, so requester 0 wins the first tie.
- States: IDLE, RUN, DONE.
- IDLE, grant selection:
  - Exactly one req_valid high: grant that requester.
  - Both high: grant the requester other than last_grant.
- IDLE, accept:
  - req_ready[g] is high combinationally while in IDLE with req_valid[g] high.
  - A handshake is req_valid[g] & req_ready[g].
  - On handshake, latch A and B (B inverted if req_sub[g]), set carry=req_sub[g], set word index k=0, record id=g, then go to RUN.
- RUN, per cycle:
  - Slice computes A[k]+B[k]+carry.
  - The sum is written to result word k; carry <= slice cout; k <= k+1.
  - After word NWORDS−1 is written, go to DONE.
- Request inputs are ignored outside IDLE; req_ready=0 in RUN and DONE.
- DONE:
  - rsp_valid=1.
  - rsp_data, rsp_cout, rsp_id and rsp_ovf are held stable until rsp_ready.
  - On rsp_valid & rsp_ready: last_grant <= id, rsp_valid deasserts next cycle, state returns to IDLE.
- Arithmetic is modulo 2^W. rsp_cout is the carry out of the top slice.
- Reset mid-RUN or mid-DONE: abort; the result is discarded and all outputs take their reset values next cycle.
  - A requester still holding req_valid is re-arbitrated from scratch.

## Timing
- Handshake in cycle T; RUN occupies T+1 … T+NWORDS; rsp_valid first high in cycle T+NWORDS+1.
- Default latency: 5 cycles from handshake to rsp_valid.
- Minimum spacing between accepts: NWORDS+2 cycles (DONE returns to IDLE on a same-cycle rsp_ready).
- IDLE re-accepts in the cycle after the response handshake, not in the same cycle.
- Slice critical path: one 4-bit lookahead level plus group carry across SLICE_W/4 groups; carry is registered between words.
- Every output is a register except req_ready.

## Configuration
- MP_ADD_OVF_EN defined:
  - rsp_ovf port exists.
  - rsp_ovf = carry into the top result bit XOR rsp_cout, captured from the final RUN cycle.
  - It is valid and held with rsp_valid.
- MP_ADD_OVF_EN undefined: the port and its logic are absent; behaviour is otherwise identical.

## Test plan
- Reset, then idle 10 cycles with no requests → all outputs 0, req_ready=00, rsp_valid never rises.
- Requester 0 adds A=0x0000_0000_0000_FFFF, B=0x1 → rsp_data=0x0000_0000_0001_0000, rsp_cout=0, rsp_id=0, rsp_valid exactly 5 cycles after handshake.
- Full-chain carry: A=0xFFFF_FFFF_FFFF_FFFF, B=0x1, add → rsp_data=0, rsp_cout=1; with MP_ADD_OVF_EN, rsp_ovf=0.
- Requester 1 subtracts A=0x5, B=0x7 → rsp_data=0xFFFF_FFFF_FFFF_FFFE, rsp_cout=0.
  - With MP_ADD_OVF_EN, also 0x7FFF_FFFF_FFFF_FFFF + 0x1 → rsp_ovf=1.
- Both req_valid high continuously with rsp_ready held low 3 cycles in DONE:
  - Grants are 0, 1, 0, 1 in order.
  - rsp_data/rsp_id are stable while stalled.
  - No req_ready pulses during RUN or DONE.
- Assert reset in the 2nd RUN cycle → next cycle rsp_valid=0 and the state is IDLE; held req_valid[0] is re-accepted and completes with the correct sum.
